// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_buf slice: depth/count-width helpers and
// the push/pop operation encoding used by the pointer controller.
package fifo_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] PUSH = 2'b10;
  localparam logic [1:0] BOTH = 2'b11;

  function automatic int fifo_depth(input int addr_bw);
    return 1 << addr_bw;
  endfunction

  function automatic int fifo_cnt_bw(input int addr_bw);
    return addr_bw + 1;
  endfunction

endpackage

// File: rtl/fifo_buf_if.sv
// Push/pop, status and error signals of fifo_buf; master is the client
// side, slave is the FIFO itself.
interface fifo_buf_if #(
  parameter int DATA_BW = 8,
  parameter int ADDR_BW = 2
);
  logic               wr_en;
  logic [DATA_BW-1:0] wr_data;
  logic               rd_en;
  logic               clr_err;
  logic [DATA_BW-1:0] rd_data;
  logic               rd_valid;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [ADDR_BW:0]   num_item;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           num_item, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           num_item, overflow, underflow
  );
endinterface

// File: rtl/fifo_buf_ptr_ctrl.sv
// Combinational pointer/count controller: accept decode, next pointers,
// next occupancy and full/empty from the registered count.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_BW = 2
) (
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic [ADDR_BW-1:0] i_wr_ptr,
  input  logic [ADDR_BW-1:0] i_rd_ptr,
  input  logic [ADDR_BW:0]   i_num_item,
  output logic               o_push,
  output logic               o_pop,
  output logic [ADDR_BW-1:0] o_nxt_wr_ptr,
  output logic [ADDR_BW-1:0] o_nxt_rd_ptr,
  output logic [ADDR_BW:0]   o_nxt_num_item,
  output logic               o_full,
  output logic               o_empty
);
  localparam int DEPTH  = fifo_depth(ADDR_BW);
  localparam int CNT_BW = fifo_cnt_bw(ADDR_BW);

  logic [1:0] w_op;

  assign o_full  = (i_num_item == CNT_BW'(DEPTH));
  assign o_empty = (i_num_item == '0);
  assign o_push  = i_wr_en & ~o_full;
  assign o_pop   = i_rd_en & ~o_empty;
  assign w_op    = {o_push, o_pop};

  // Pointers wrap by natural overflow of the ADDR_BW-wide add.
  assign o_nxt_wr_ptr = o_push ? i_wr_ptr + ADDR_BW'(1) : i_wr_ptr;
  assign o_nxt_rd_ptr = o_pop  ? i_rd_ptr + ADDR_BW'(1) : i_rd_ptr;

  always_comb begin
    o_nxt_num_item = i_num_item;
    case (w_op)
      PUSH:    o_nxt_num_item = i_num_item + CNT_BW'(1);
      POP:     o_nxt_num_item = i_num_item - CNT_BW'(1);
      IDLE,
      BOTH:    o_nxt_num_item = i_num_item;
      default: o_nxt_num_item = i_num_item;
    endcase
  end

endmodule

// File: rtl/fifo_buf.sv
// Parametrised synchronous FIFO with threshold flags, sticky overflow/underflow
// and a selectable first-word-fall-through or registered read port.
module fifo_buf
  import fifo_pkg::*;
#(
  parameter int DATA_BW   = 8,
  parameter int ADDR_BW   = 2,
  parameter int AF_THRESH = 2**ADDR_BW - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 1
) (
  input logic      clk,
  input logic      rst,
  fifo_buf_if.slave bus
);
  localparam int DEPTH  = fifo_depth(ADDR_BW);
  localparam int CNT_BW = fifo_cnt_bw(ADDR_BW);
  localparam logic [CNT_BW-1:0] AF_C = CNT_BW'(AF_THRESH);
  localparam logic [CNT_BW-1:0] AE_C = CNT_BW'(AE_THRESH);

  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_buf: AF_THRESH must lie in 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("fifo_buf: AE_THRESH must lie in 0..DEPTH");
  end

  logic [DATA_BW-1:0] r_mem [DEPTH];
  logic [ADDR_BW-1:0] r_wr_ptr;
  logic [ADDR_BW-1:0] r_rd_ptr;
  logic [CNT_BW-1:0]  r_num_item;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ADDR_BW-1:0] w_nxt_wr_ptr;
  logic [ADDR_BW-1:0] w_nxt_rd_ptr;
  logic [CNT_BW-1:0]  w_nxt_num_item;

  fifo_ptr_ctrl #(.ADDR_BW(ADDR_BW)) u_ptr_ctrl (
    .i_wr_en        (bus.wr_en),
    .i_rd_en        (bus.rd_en),
    .i_wr_ptr       (r_wr_ptr),
    .i_rd_ptr       (r_rd_ptr),
    .i_num_item     (r_num_item),
    .o_push         (w_push),
    .o_pop          (w_pop),
    .o_nxt_wr_ptr   (w_nxt_wr_ptr),
    .o_nxt_rd_ptr   (w_nxt_rd_ptr),
    .o_nxt_num_item (w_nxt_num_item),
    .o_full         (w_full),
    .o_empty        (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_num_item <= '0;
    end else begin
      r_wr_ptr   <= w_nxt_wr_ptr;
      r_rd_ptr   <= w_nxt_rd_ptr;
      r_num_item <= w_nxt_num_item;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  // A new error event wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.wr_en & w_full)  | (r_overflow  & ~bus.clr_err);
      r_underflow <= (bus.rd_en & w_empty) | (r_underflow & ~bus.clr_err);
    end
  end

  assign bus.num_item     = r_num_item;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_num_item >= AF_C);
  assign bus.almost_empty = (r_num_item <= AE_C);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = r_mem[r_rd_ptr];
    assign bus.rd_valid = ~w_empty;
  end else begin : g_reg_read
    logic [DATA_BW-1:0] r_rd_data;
    logic               r_rd_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_pop;
        if (w_pop) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
  end

endmodule
